// File: rtl/tt_um_hamming_encoder_74.sv
// Hamming(7,4) encoder front end for the UART TX path: nibble FIFO, encoder,
// one-entry codeword output register with valid/ready and optional single-bit error injection.

module hamming74_enc (
  input  logic [3:0] data,
  output logic [6:0] code
);
  logic c0, c1, c2;

  // Parity order matches the receive-side syndrome bits.
  assign c0   = data[0] ^ data[1] ^ data[3];
  assign c1   = data[0] ^ data[2] ^ data[3];
  assign c2   = data[1] ^ data[2] ^ data[3];
  assign code = {data[3], data[2], data[1], c2, data[0], c1, c0};
endmodule

module tt_um_hamming_encoder_74 #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid_in,
  output logic       data_ready_out,
  output logic [6:0] code_out,
  output logic       code_valid_out,
  input  logic       code_ready_in,
  input  logic [2:0] inject_err_in,
  output logic [2:0] debug_count_out
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][3:0] mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [2:0]                 count;
  logic                       push, pop;
  logic [6:0]                 enc_code, flip;

  // Ready depends only on registered count, never on code_ready_in.
  assign data_ready_out  = rst_n && ena && (count < 3'(FIFO_DEPTH));
  assign push            = data_valid_in && data_ready_out;
  assign pop             = ena && (count != 3'd0) && (!code_valid_out || code_ready_in);
  assign debug_count_out = count;

  hamming74_enc u_enc (
    .data (mem[rd_ptr]),
    .code (enc_code)
  );

  assign flip = (inject_err_in == 3'd0) ? 7'd0 : (7'd1 << (inject_err_in - 3'd1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out       <= '0;
      code_valid_out <= 1'b0;
    end else if (pop) begin
      code_out       <= enc_code ^ flip;
      code_valid_out <= 1'b1;
    end else if (ena && code_valid_out && code_ready_in) begin
      code_valid_out <= 1'b0;
    end
  end
endmodule
